// File: rtl/mux_rx_fifo.sv
// mux_rx_fifo: receive-side byte FIFO with overrun tracking and a simple
// request/acknowledge interrupt controller.
//
// Each entry holds {rx_error, rx_data}. The head entry is presented
// combinationally (first-word-fall-through). count/empty/full are registered
// and always agree with the pointer state.
//
// Optional feature macro: MUX_RX_WATERMARK_EN
//   undefined : interrupt trigger = FIFO not empty (watermark port ignored)
//   defined   : interrupt trigger = (count >= watermark) or overrun,
//               with watermark=0 treated as 1
module mux_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_error,
    input  logic             rd_en,
    input  logic             clear_overrun,
    input  logic             int_enable,
    input  logic [3:0]       int_level,
    input  logic             int_ack,
    input  logic [CNT_W-1:0] watermark,
    output logic [7:0]       rd_data,
    output logic             rd_error,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overrun,
    output logic             int_reqn,
    output logic [3:0]       irq_number
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_ACKED   = 2'd2
    } irq_state_t;

    // Storage is not reset: pointers and count define which entries are live.
    logic [8:0]       mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overrun_q, overrun_d;

    irq_state_t       state_q, state_d;
    logic             int_reqn_q, int_reqn_d;
    logic [3:0]       irq_number_q, irq_number_d;

    logic             do_wr;
    logic             do_rd;
    logic             drop;
    logic             mem_we;
    logic             trigger;

    // Accept/drop decisions; a full FIFO still accepts a write when a read frees a slot.
    always_comb begin
        do_rd  = rd_en && !empty_q;
        do_wr  = rx_valid && (!full_q || rd_en);
        drop   = rx_valid && full_q && !rd_en;
        mem_we = do_wr && !reset;
    end

    // Next pointer, occupancy and flag values.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {rx_error, rx_data};
        end
    end

`ifdef MUX_RX_WATERMARK_EN
    logic [CNT_W-1:0] wm_eff;

    // Threshold trigger; a zero threshold behaves like a threshold of one.
    always_comb begin
        wm_eff  = (watermark == '0) ? CNT_W'(1) : watermark;
        trigger = (count_q >= wm_eff) || overrun_q;
    end
`else
    logic unused_watermark;
    assign unused_watermark = ^watermark;

    // Trigger whenever at least one byte is waiting.
    always_comb begin
        trigger = !empty_q;
    end
`endif

    // Interrupt next-state logic; disabling always returns to idle.
    always_comb begin
        state_d      = state_q;
        irq_number_d = irq_number_q;
        if (!int_enable) begin
            state_d = IRQ_IDLE;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (trigger) begin
                        state_d = IRQ_PENDING;
                    end
                end
                IRQ_PENDING: begin
                    if (int_ack) begin
                        state_d = IRQ_ACKED;
                    end
                end
                IRQ_ACKED: begin
                    if (!trigger) begin
                        state_d = IRQ_IDLE;
                    end
                end
                default: state_d = IRQ_IDLE;
            endcase
        end
        int_reqn_d = (state_d != IRQ_PENDING);
        if (state_d == IRQ_PENDING) begin
            irq_number_d = int_level;
        end
    end

    // Interrupt state and registered request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IRQ_IDLE;
            int_reqn_q   <= 1'b1;
            irq_number_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            int_reqn_q   <= int_reqn_d;
            irq_number_q <= irq_number_d;
        end
    end

    assign rd_data    = mem_q[rd_ptr_q][7:0];
    assign rd_error   = mem_q[rd_ptr_q][8];
    assign empty      = empty_q;
    assign full       = full_q;
    assign count      = count_q;
    assign overrun    = overrun_q;
    assign int_reqn   = int_reqn_q;
    assign irq_number = irq_number_q;

endmodule

// File: tb/tb_mux_rx_fifo.sv
// Testbench for mux_rx_fifo: directed stimulus, a queue-based reference model
// and a per-cycle compare process, plus literal expectations at key points.
// Honours MUX_RX_WATERMARK_EN the same way the design does.
module tb_mux_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_error;
    logic             rd_en;
    logic             clear_overrun;
    logic             int_enable;
    logic [3:0]       int_level;
    logic             int_ack;
    logic [CNT_W-1:0] watermark;
    logic [7:0]       rd_data;
    logic             rd_error;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overrun;
    logic             int_reqn;
    logic [3:0]       irq_number;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    logic [8:0] mq[$];
    bit         m_ov;
    int         m_st;      // 0 idle, 1 pending, 2 acknowledged
    bit         m_irqn;
    logic [3:0] m_irqnum;

    mux_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_error(rx_error), .rd_en(rd_en), .clear_overrun(clear_overrun),
        .int_enable(int_enable), .int_level(int_level), .int_ack(int_ack),
        .watermark(watermark), .rd_data(rd_data), .rd_error(rd_error),
        .empty(empty), .full(full), .count(count), .overrun(overrun),
        .int_reqn(int_reqn), .irq_number(irq_number)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_trigger(input int n, input bit ov);
`ifdef MUX_RX_WATERMARK_EN
        int wm;
        wm = (watermark == 0) ? 1 : int'(watermark);
        return (n >= wm) || ov;
`else
        return n > 0;
`endif
    endfunction

    // Reference model: advance on each rising edge from pre-edge state.
    always @(posedge clk) begin
        int  n;
        bit  trig;
        bit  rd;
        bit  wr;
        n    = mq.size();
        trig = model_trigger(n, m_ov);
        if (reset) begin
            mq.delete();
            m_ov     = 1'b0;
            m_st     = 0;
            m_irqn   = 1'b1;
            m_irqnum = 4'd0;
        end else begin
            rd = rd_en && (n > 0);
            wr = rx_valid && ((n < DEPTH) || rd_en);
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back({rx_error, rx_data});
            if (rx_valid && (n == DEPTH) && !rd_en) m_ov = 1'b1;
            else if (clear_overrun) m_ov = 1'b0;
            if (!int_enable) m_st = 0;
            else if (m_st == 0 && trig) m_st = 1;
            else if (m_st == 1 && int_ack) m_st = 2;
            else if (m_st == 2 && !trig) m_st = 0;
            m_irqn = (m_st != 1);
            if (m_st == 1) m_irqnum = int_level;
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("overrun", 32'(overrun), 32'(m_ov));
            chk("int_reqn", 32'(int_reqn), 32'(m_irqn));
            if (mq.size() > 0) begin
                chk("rd_data", 32'(rd_data), 32'(mq[0][7:0]));
                chk("rd_error", 32'(rd_error), 32'(mq[0][8]));
            end
            if (!m_irqn) chk("irq_number", 32'(irq_number), 32'(m_irqnum));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        rx_valid = 1'b1; rx_data = d; rx_error = e;
        step();
        rx_valid = 1'b0; rx_error = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
        rd_en = 1'b0; clear_overrun = 1'b0; int_enable = 1'b0;
        int_level = 4'd0; int_ack = 1'b0; watermark = '0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_count", 32'(count), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_int_reqn", 32'(int_reqn), 1);
        chk("reset_irq_number", 32'(irq_number), 0);

        // Basic write / FWFT read
        push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0);
        chk("basic_count", 32'(count), 3);
        chk("basic_head", 32'(rd_data), 32'h41);
        chk("model_size3", 32'(mq.size()), 3);
        pop(); chk("basic_head2", 32'(rd_data), 32'h42);
        pop(); chk("basic_head3", 32'(rd_data), 32'h43);
        pop(); chk("basic_empty", 32'(empty), 1);
        pop(); chk("rd_empty_ignored", 32'(count), 0);

        // Overflow: 17 writes, 17th dropped
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i), 1'b0);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_overrun", 32'(overrun), 1);
        clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
        chk("ovf_cleared", 32'(overrun), 0);
        rx_valid = 1'b1; rx_data = 8'hEE; clear_overrun = 1'b1;
        step();
        rx_valid = 1'b0; clear_overrun = 1'b0;
        chk("drop_beats_clear", 32'(overrun), 1);
        clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain", 32'(rd_data), 32'(8'h10 + i));
            pop();
        end
        chk("ovf_17th_absent", 32'(empty), 1);

        // Simultaneous read/write while full
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i), 1'b0);
        rx_valid = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
        step();
        rx_valid = 1'b0; rd_en = 1'b0;
        chk("fullrw_count", 32'(count), 16);
        chk("fullrw_overrun", 32'(overrun), 0);
        chk("fullrw_head", 32'(rd_data), 32'h61);
        for (int i = 0; i < 15; i++) pop();
        chk("fullrw_last", 32'(rd_data), 32'h55);
        pop();

        // Simultaneous read/write while empty
        rx_valid = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
        step();
        rx_valid = 1'b0; rd_en = 1'b0;
        chk("emptyrw_count", 32'(count), 1);
        chk("emptyrw_head", 32'(rd_data), 32'h77);
        pop();

`ifndef MUX_RX_WATERMARK_EN
        // Interrupt handshake on not-empty trigger
        int_level = 4'd5; int_enable = 1'b1;
        step();
        push(8'h33, 1'b0);
        chk("irq_not_yet", 32'(int_reqn), 1);
        step();
        chk("irq_asserted", 32'(int_reqn), 0);
        chk("irq_number", 32'(irq_number), 5);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("irq_acked", 32'(int_reqn), 1);
        step();
        chk("irq_acked_hold", 32'(int_reqn), 1);
        pop();
        step();
        push(8'h34, 1'b0);
        step();
        chk("irq_rearmed", 32'(int_reqn), 0);
        int_enable = 1'b0; step();
        chk("irq_disabled", 32'(int_reqn), 1);
        pop();
`endif

        // Error flag tracking per entry
        push(8'hA1, 1'b0); push(8'hA2, 1'b1); push(8'hA3, 1'b0);
        chk("err_first", 32'(rd_error), 0);
        pop(); chk("err_second", 32'(rd_error), 1);
        pop(); chk("err_third", 32'(rd_error), 0);
        pop();

        // Streaming across two and a half pointer wraps
        for (int i = 0; i < 40; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'h80 + i); rx_error = (i == 5);
            rd_en = (i >= 2);
            step();
        end
        rx_valid = 1'b0; rx_error = 1'b0; rd_en = 1'b0;
        chk("wrap_count", 32'(count), 2);
        chk("wrap_head", 32'(rd_data), 32'hA6);
        pop(); pop();

        // Reset mid-operation with traffic in the reset cycle
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 1'b0);
        reset = 1'b1; rx_valid = 1'b1; rd_en = 1'b1;
        step();
        reset = 1'b0; rx_valid = 1'b0; rd_en = 1'b0;
        chk("midreset_count", 32'(count), 0);
        chk("midreset_empty", 32'(empty), 1);
        step();

`ifdef MUX_RX_WATERMARK_EN
        // Watermark trigger
        watermark = CNT_W'(4); int_level = 4'd9; int_enable = 1'b1;
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
        step();
        chk("wm_below", 32'(int_reqn), 1);
        push(8'h04, 1'b0);
        chk("wm_edge", 32'(int_reqn), 1);
        step();
        chk("wm_reached", 32'(int_reqn), 0);
        chk("wm_irq_number", 32'(irq_number), 9);
        int_enable = 1'b0;
        for (int i = 0; i < 4; i++) pop();
`endif
        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
